// File: rtl/contador_tiros_pkg.sv
// contador_tiros_pkg -- shared definitions for the multi-channel throw counter.
//   estado_t     : per-channel FSM state
//   CANALES_DEF  : default number of channels
//   ANCHO_DEF    : default counter width
//   valor_reset(): reset count 2^(ancho-1)
package contador_tiros_pkg;

  localparam int unsigned CANALES_DEF = 4;
  localparam int unsigned ANCHO_DEF   = 6;

  typedef enum logic [1:0] {
    CONTANDO  = 2'd0,
    CARGANDO  = 2'd1,
    TERMINADO = 2'd2
  } estado_t;

  function automatic logic [15:0] valor_reset(input int unsigned ancho);
    logic [15:0] v;
    v = '0;
    v[ancho-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/contador_tiros_multi_if.sv
// contador_tiros_multi_if -- control/status bundle of contador_tiros_multi.
//   clk_en_i      : shared decrement-tick enable
//   iniciar_i     : per-channel load/spin request (level)
//   decrementar_i : per-channel decrement request
//   autorecarga_i : per-channel auto-reload enable (CONTADOR_TIROS_AUTORECARGA_EN only)
//   cuenta_o      : packed counts, channel k at [k*ANCHO +: ANCHO]
//   done_o        : per-channel count==0
//   fin_o         : per-channel one-cycle pulse on 1->0
//   todos_done_o  : AND of done_o
// Modports: master drives requests, slave is the counter block.
interface contador_tiros_multi_if #(
  parameter int unsigned CANALES = 4,
  parameter int unsigned ANCHO   = 6
) ();

  logic                       clk_en_i;
  logic [CANALES-1:0]         iniciar_i;
  logic [CANALES-1:0]         decrementar_i;
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
  logic [CANALES-1:0]         autorecarga_i;
`endif
  logic [CANALES*ANCHO-1:0]   cuenta_o;
  logic [CANALES-1:0]         done_o;
  logic [CANALES-1:0]         fin_o;
  logic                       todos_done_o;

  modport master (
    output clk_en_i, iniciar_i, decrementar_i,
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
    output autorecarga_i,
`endif
    input  cuenta_o, done_o, fin_o, todos_done_o
  );

  modport slave (
    input  clk_en_i, iniciar_i, decrementar_i,
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
    input  autorecarga_i,
`endif
    output cuenta_o, done_o, fin_o, todos_done_o
  );

endinterface

// File: rtl/contador_tiros_canal.sv
// contador_tiros_canal -- one throw-counter channel.
//   clk_i, rst_i   : clock, async active-high reset (already release-synchronised)
//   clk_en_i       : decrement-tick enable
//   iniciar_i      : load/spin request, has priority over decrement
//   decrementar_i  : decrement request
//   autorecarga_i  : reload from TERMINADO (only with CONTADOR_TIROS_AUTORECARGA_EN)
//   cuenta_o       : registered count
//   done_o         : count==0, decoded from the register
//   fin_o          : one-cycle pulse after the decrement that reaches 0
module contador_tiros_canal
  import contador_tiros_pkg::*;
#(
  parameter int unsigned ANCHO = ANCHO_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic             iniciar_i,
  input  logic             decrementar_i,
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
  input  logic             autorecarga_i,
`endif
  output logic [ANCHO-1:0] cuenta_o,
  output logic             done_o,
  output logic             fin_o
);

  localparam logic [15:0]      RST_FULL = valor_reset(ANCHO);
  localparam logic [ANCHO-1:0] CNT_RST  = RST_FULL[ANCHO-1:0];

  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] cuenta_q, cuenta_d;
  logic             fin_q, fin_d;
  logic [ANCHO-2:0] bajo_inc;
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
  logic [ANCHO-1:0] captura_q, captura_d;
`endif

  assign bajo_inc = cuenta_q[ANCHO-2:0] + (ANCHO-1)'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_q  <= CONTANDO;
      cuenta_q  <= CNT_RST;
      fin_q     <= 1'b0;
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
      captura_q <= CNT_RST;
`endif
    end else begin
      estado_q  <= estado_d;
      cuenta_q  <= cuenta_d;
      fin_q     <= fin_d;
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
      captura_q <= captura_d;
`endif
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cuenta_d  = cuenta_q;
    fin_d     = 1'b0;
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
    captura_d = captura_q;
`endif
    if (iniciar_i) begin
      // Every edge with iniciar_i high spins, including the one that enters
      // CARGANDO, so N held edges add N to the low bits.
      estado_d = CARGANDO;
      cuenta_d = {1'b1, bajo_inc};
    end else begin
      unique case (estado_q)
        CARGANDO: begin
          estado_d  = CONTANDO;
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
          captura_d = cuenta_q;
`endif
        end
        CONTANDO: begin
          if (clk_en_i && decrementar_i && (cuenta_q != '0)) begin
            cuenta_d = cuenta_q - ANCHO'(1);
            if (cuenta_q == ANCHO'(1)) begin
              estado_d = TERMINADO;
              fin_d    = 1'b1;
            end
          end
        end
        TERMINADO: begin
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
          if (autorecarga_i && clk_en_i) begin
            estado_d = CONTANDO;
            cuenta_d = captura_q;
          end
`endif
        end
        default: estado_d = CONTANDO;
      endcase
    end
  end

  assign cuenta_o = cuenta_q;
  assign done_o   = (cuenta_q == '0);
  assign fin_o    = fin_q;

endmodule

// File: rtl/contador_tiros_multi.sv
// contador_tiros_multi -- CANALES independent throw counters of ANCHO bits.
//   clk_i : system clock
//   rst_i : async active-high reset; assertion is immediate, release is
//           synchronised to clk_i
//   bus   : contador_tiros_multi_if.slave (requests in, counts/status out)
// Optional feature: define CONTADOR_TIROS_AUTORECARGA_EN for per-channel
// auto-reload from TERMINADO.
module contador_tiros_multi
  import contador_tiros_pkg::*;
#(
  parameter int unsigned CANALES = CANALES_DEF,
  parameter int unsigned ANCHO   = ANCHO_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  contador_tiros_multi_if.slave bus
);

  logic [1:0]               rst_sync_q;
  logic                     rst_int;
  logic [CANALES*ANCHO-1:0] cuenta_v;
  logic [CANALES-1:0]       done_v;
  logic [CANALES-1:0]       fin_v;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_sync_q <= '1;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  for (genvar k = 0; k < CANALES; k++) begin : g_canal
    contador_tiros_canal #(
      .ANCHO(ANCHO)
    ) u_canal (
      .clk_i         (clk_i),
      .rst_i         (rst_int),
      .clk_en_i      (bus.clk_en_i),
      .iniciar_i     (bus.iniciar_i[k]),
      .decrementar_i (bus.decrementar_i[k]),
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
      .autorecarga_i (bus.autorecarga_i[k]),
`endif
      .cuenta_o      (cuenta_v[k*ANCHO +: ANCHO]),
      .done_o        (done_v[k]),
      .fin_o         (fin_v[k])
    );
  end

  assign bus.cuenta_o     = cuenta_v;
  assign bus.done_o       = done_v;
  assign bus.fin_o        = fin_v;
  assign bus.todos_done_o = &done_v;

endmodule

// File: tb/tb_contador_tiros_multi.sv
// tb_contador_tiros_multi -- directed self-checking bench for
// contador_tiros_multi at CANALES=4, ANCHO=6.
// Extra checks run when CONTADOR_TIROS_AUTORECARGA_EN is defined.
module tb_contador_tiros_multi;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  int unsigned n_pruebas = 0;
  int unsigned n_fallos  = 0;

  contador_tiros_multi_if #(.CANALES(4), .ANCHO(6)) bus ();

  contador_tiros_multi #(
    .CANALES(4),
    .ANCHO  (6)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_pruebas++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: obtenido=%0d esperado=%0d", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [5:0] ch(input int unsigned k);
    return bus.cuenta_o[k*6 +: 6];
  endfunction

  initial begin
    int unsigned en;
    int unsigned fins;
    bus.clk_en_i      = 1'b0;
    bus.iniciar_i     = '0;
    bus.decrementar_i = '0;
`ifdef CONTADOR_TIROS_AUTORECARGA_EN
    bus.autorecarga_i = '0;
`endif

    // Asynchronous reset between edges
    #2 rst_i = 1'b1;
    #1;
    chequear("rst_cuenta", 32'(bus.cuenta_o), 32'({6'd32, 6'd32, 6'd32, 6'd32}));
    chequear("rst_done", 32'(bus.done_o), 32'd0);
    chequear("rst_fin", 32'(bus.fin_o), 32'd0);
    chequear("rst_todos", 32'(bus.todos_done_o), 32'd0);
    tick(); tick();
    #2 rst_i = 1'b0;
    tick(); tick(); tick();
    chequear("post_rst_cuenta", 32'(bus.cuenta_o), 32'({6'd32, 6'd32, 6'd32, 6'd32}));

    // Load then count
    bus.iniciar_i = 4'b0001;
    tick(); tick(); tick();
    chequear("carga3_ch0", 32'(ch(0)), 32'd35);
    bus.iniciar_i = '0;
    tick();
    chequear("salida_carga_ch0", 32'(ch(0)), 32'd35);
    bus.decrementar_i = 4'b0001;
    en = 0;
    fins = 0;
    for (int unsigned cyc = 0; cyc < 148; cyc++) begin
      bus.clk_en_i = ((cyc % 4) == 3);
      tick();
      if (bus.clk_en_i) begin
        en++;
        if (en == 20) chequear("mitad_ch0", 32'(ch(0)), 32'd15);
      end
      if (bus.fin_o[0]) fins++;
    end
    chequear("fin_ch0_pulsos", fins, 32'd1);
    chequear("final_ch0", 32'(ch(0)), 32'd0);
    chequear("done_tras_cuenta", 32'(bus.done_o), 32'b0001);
    chequear("otros_32", 32'(bus.cuenta_o[23:6]), 32'({6'd32, 6'd32, 6'd32}));
    chequear("todos_parcial", 32'(bus.todos_done_o), 32'd0);

    // Gating: no enable, no change
    bus.clk_en_i      = 1'b0;
    bus.decrementar_i = 4'b1111;
    repeat (50) tick();
    chequear("gating", 32'(bus.cuenta_o), 32'({6'd32, 6'd32, 6'd32, 6'd0}));
    // TERMINADO ignores decrements
    bus.decrementar_i = 4'b0001;
    bus.clk_en_i      = 1'b1;
    tick();
    chequear("terminado_ignora", 32'(ch(0)), 32'd0);
    chequear("terminado_fin", 32'(bus.fin_o), 32'd0);
    bus.decrementar_i = '0;
    bus.clk_en_i      = 1'b0;

    // Wrap and priority on channel 1
    bus.iniciar_i = 4'b0010;
    repeat (33) tick();
    chequear("wrap_ch1", 32'(ch(1)), 32'd33);
    bus.decrementar_i = 4'b0010;
    bus.clk_en_i      = 1'b1;
    tick();
    chequear("prioridad_ch1", 32'(ch(1)), 32'd34);
    bus.iniciar_i     = '0;
    bus.decrementar_i = '0;
    bus.clk_en_i      = 1'b0;
    tick();
    chequear("retencion_ch1", 32'(ch(1)), 32'd34);
    bus.decrementar_i = 4'b0010;
    bus.clk_en_i      = 1'b1;
    tick();
    chequear("decr_ch1", 32'(ch(1)), 32'd33);

    // Channel 3 down to 6, then simultaneous load ch2 / decrement ch3
    bus.decrementar_i = 4'b1000;
    repeat (26) tick();
    chequear("ch3_a_6", 32'(ch(3)), 32'd6);
    bus.iniciar_i = 4'b0100;
    tick();
    chequear("simul_ch2", 32'(ch(2)), 32'd33);
    chequear("simul_ch3", 32'(ch(3)), 32'd5);
    bus.decrementar_i = '0;
    bus.clk_en_i      = 1'b0;

    // Reset mid-operation (ch2 in CARGANDO, ch3 at 5)
    #2 rst_i = 1'b1;
    #1;
    chequear("rst_medio_cuenta", 32'(bus.cuenta_o), 32'({6'd32, 6'd32, 6'd32, 6'd32}));
    chequear("rst_medio_done", 32'(bus.done_o), 32'd0);
    chequear("rst_medio_fin", 32'(bus.fin_o), 32'd0);
    bus.iniciar_i = '0;
    tick(); tick();
    chequear("rst_medio_fin2", 32'(bus.fin_o), 32'd0);
    #2 rst_i = 1'b0;
    tick(); tick(); tick();

    // All channels to zero together
    bus.decrementar_i = 4'b1111;
    bus.clk_en_i      = 1'b1;
    repeat (31) tick();
    chequear("todos_a_1", 32'(bus.cuenta_o), 32'({6'd1, 6'd1, 6'd1, 6'd1}));
    chequear("todos_a_1_fin", 32'(bus.fin_o), 32'd0);
    tick();
    chequear("todos_cero", 32'(bus.cuenta_o), 32'd0);
    chequear("todos_fin", 32'(bus.fin_o), 32'b1111);
    chequear("todos_done", 32'(bus.done_o), 32'b1111);
    chequear("todos_done_and", 32'(bus.todos_done_o), 32'd1);
    bus.decrementar_i = '0;
    bus.clk_en_i      = 1'b0;
    tick();
    chequear("fin_un_ciclo", 32'(bus.fin_o), 32'd0);

`ifndef CONTADOR_TIROS_AUTORECARGA_EN
    // Without auto-reload, TERMINADO persists even with enable
    bus.clk_en_i = 1'b1;
    repeat (3) tick();
    chequear("sin_autorecarga", 32'(bus.cuenta_o), 32'd0);
    bus.clk_en_i = 1'b0;
`endif

    // Restart from TERMINADO via iniciar
    bus.iniciar_i = 4'b0001;
    tick();
    chequear("recarga_ch0", 32'(ch(0)), 32'd33);
    chequear("recarga_done", 32'(bus.done_o), 32'b1110);
    chequear("recarga_todos", 32'(bus.todos_done_o), 32'd0);

`ifdef CONTADOR_TIROS_AUTORECARGA_EN
    tick();
    chequear("auto_carga34", 32'(ch(0)), 32'd34);
    bus.iniciar_i = '0;
    tick();
    bus.autorecarga_i = 4'b0001;
    bus.decrementar_i = 4'b0001;
    bus.clk_en_i      = 1'b1;
    repeat (33) tick();
    chequear("auto_a_1", 32'(ch(0)), 32'd1);
    tick();
    chequear("auto_cero", 32'(ch(0)), 32'd0);
    chequear("auto_fin", 32'(bus.fin_o[0]), 32'd1);
    tick();
    chequear("auto_recargado", 32'(ch(0)), 32'd34);
    chequear("auto_fin_bajo", 32'(bus.fin_o[0]), 32'd0);
    tick();
    chequear("auto_sigue", 32'(ch(0)), 32'd33);
`endif
    bus.iniciar_i = '0;

    $display("[TB] %0d tests run, %0d failed", n_pruebas, n_fallos);
    $finish;
  end

endmodule

// File: doc/contador_tiros_multi.md
CONTADOR_TIROS_MULTI -- requirements
Module: contador_tiros_multi

Interface
REQ-001 The block SHALL have parameter CANALES, default 4, meaning the number of independent throw counters (1..16).
REQ-002 The block SHALL have parameter ANCHO, default 6, meaning the counter width in bits (3..16).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  in  1  system clock; all state SHALL update on its rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 clk_en_i  in  1  decrement-tick enable, shared by all channels.
REQ-007 iniciar_i  in  CANALES  per-channel load/spin request, level-sensitive.
REQ-008 decrementar_i  in  CANALES  per-channel decrement request.
REQ-009 cuenta_o  out  CANALES*ANCHO  packed per-channel count; channel k SHALL occupy bits [k*ANCHO +: ANCHO].
REQ-010 done_o  out  CANALES  per-channel level, high while that channel's count equals 0.
REQ-011 fin_o  out  CANALES  per-channel one-cycle pulse on the 1->0 count transition.
REQ-012 todos_done_o  out  1  AND of all done_o bits.

Function
REQ-013 Each channel SHALL run a 3-state FSM: CONTANDO, CARGANDO, TERMINADO.
REQ-014 From any state, iniciar_i[k]=1 SHALL move channel k to CARGANDO on the next edge.
REQ-015 In CARGANDO, each clk_i edge with iniciar_i[k]=1 SHALL set the count MSB to 1 and increment the low ANCHO-1 bits modulo 2^(ANCHO-1), independent of clk_en_i.
REQ-016 CARGANDO SHALL exit to CONTANDO on the first edge with iniciar_i[k]=0; the count SHALL be held on that edge.
REQ-017 In CONTANDO, the count SHALL decrement by 1 on an edge with clk_en_i=1, decrementar_i[k]=1 and count!=0; otherwise it SHALL hold.
REQ-018 The decrement that produces count 0 SHALL move the channel to TERMINADO on the same edge.
REQ-019 fin_o[k] SHALL be high for exactly the one cycle following that edge.
REQ-020 In TERMINADO, the count SHALL hold at 0 and decrement requests SHALL be ignored.
REQ-021 iniciar_i[k] SHALL take priority over a simultaneous decrement.
REQ-022 done_o SHALL be decoded from registered count only, with no input-to-output combinational path.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL each take effect in the same cycle.

Reset
REQ-024 While rst_i=1, every channel SHALL be in CONTANDO with count 2^(ANCHO-1), i.e. 32 at ANCHO=6.
REQ-025 While rst_i=1, done_o, fin_o and todos_done_o SHALL be 0.
REQ-026 Reset assertion SHALL take effect immediately, without waiting for a clock edge, including mid-load and mid-count.
REQ-027 Reset release SHALL be synchronised internally so that deassertion is clean to clk_i.

Configuration
REQ-028 Macro CONTADOR_TIROS_AUTORECARGA_EN, when defined, SHALL add input autorecarga_i (CANALES bits) and a per-channel register holding the count captured on CARGANDO exit.
REQ-029 With the macro defined, a channel in TERMINADO with autorecarga_i[k]=1 SHALL reload the captured count and return to CONTANDO on the next edge with clk_en_i=1.
REQ-030 The fin_o[k] pulse SHALL still occur on an auto-reload.
REQ-031 Without the macro, the port and registers SHALL be absent, and TERMINADO SHALL be left only via iniciar_i or reset.

Structure
REQ-032 Package contador_tiros_pkg SHALL hold the FSM state enum, the parameter defaults, and the reset-value function 2^(ANCHO-1).
REQ-033 One sub-module, contador_tiros_canal, SHALL implement a single channel and SHALL be instantiated CANALES times by a generate loop.
REQ-034 The top SHALL contain only the generate loop, output packing, the todos_done_o reduction and the reset synchroniser.

Verification
REQ-035 Reset: pulse rst_i asynchronously between edges -> all cuenta_o=32 immediately; done_o=0, fin_o=0.
REQ-036 Load then count: from reset, hold iniciar_i[0] for 3 edges -> count 35; then decrementar_i[0]=1 with clk_en_i every 4th cycle -> count reaches 0 after 35 enables, exactly one fin_o[0] pulse, done_o[0]=1, other channels stay at 32.
REQ-037 Gating: decrementar_i=all ones, clk_en_i=0 for 50 cycles -> no count changes.
REQ-038 Wrap and priority: hold iniciar_i[1] for 33 edges from 32 -> count 33 (MSB kept); assert iniciar_i and decrementar_i with clk_en_i together -> load wins.
REQ-039 Reset mid-operation: assert rst_i while channel 2 is in CARGANDO and channel 3 is at count 5 -> both return to 32 immediately; no fin_o pulse.
REQ-040 With CONTADOR_TIROS_AUTORECARGA_EN defined: load 34, count to 0 with autorecarga_i[0]=1 -> fin_o[0] pulses, count returns to 34 on the next enable, and counting continues.
